lsu_mem_port: RTL and testbench

- Load/store unit for the RV32I core. It consumes the effective address computed by the ALU for OP_L/OP_S instructions, together with opcode, func3 and rs2 data.
- It drives a single-outstanding, word-wide data-memory request/grant/response handshake.
- It returns a sign- or zero-extended load result, or a store completion, to the writeback stage.

---
 rtl/lsu_mem_port_pkg.sv | 80 ++++++++
 rtl/lsu_mem_port_if.sv | 41 ++++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu_mem_port.sv | 124 ++++++++++++
 tb/tb_lsu_mem_port.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: shared constants and helpers for the load/store unit.
//   - RV32I load/store opcodes and func3 codes
//   - resp_err codes
//   - FSM state encoding
//   - request legality check and store lane formatting
package lsu_mem_port_pkg;

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } lsu_state_t;

  // Unknown opcode/func3 or a misaligned half/word access.
  function automatic logic req_illegal(input logic [6:0] opcode,
                                       input logic [2:0] func3,
                                       input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    if (opcode == OP_L) begin
      case (func3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = lo[0];
        F3_LW:         bad = (lo != 2'b00);
        default:       bad = 1'b1;
      endcase
    end else if (opcode == OP_S) begin
      case (func3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = lo[0];
        F3_SW:   bad = (lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] func3,
                                             input logic [1:0] lo);
    logic [3:0] s;
    case (func3)
      F3_SB:   s = 4'b0001 << lo;
      F3_SH:   s = lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Store data is replicated across all lanes; wstrb selects the live ones.
  function automatic logic [31:0] store_wdata(input logic [2:0]  func3,
                                              input logic [31:0] rs2);
    logic [31:0] d;
    case (func3)
      F3_SB:   d = {4{rs2[7:0]}};
      F3_SH:   d = {2{rs2[15:0]}};
      default: d = rs2;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: core request, data-memory and writeback response signals
// of the load/store unit.
//   master : the LSU (drives memory requests and writeback responses)
//   slave  : the environment (core pipeline and data memory)
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport master (
    input  req_valid, req_opcode, req_func3, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport slave (
    output req_valid, req_opcode, req_func3, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts and extends a load result from a memory word.
//   rdata : 32-bit word read from memory
//   func3 : LB/LH/LW/LBU/LHU
//   addr  : byte offset within the word (addr[1:0])
//   data  : sign/zero-extended result (LW passes the word through)
module lsu_load_align
  import lsu_mem_port_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];

    case (func3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LBU:  data = {24'h000000, b};
      F3_LHU:  data = {16'h0000, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store unit with a single-outstanding data-memory
// request/grant/response handshake.
//   clk, rst_n : core clock (rising edge), asynchronous active-low reset
//   bus        : lsu_mem_port_if.master
//     req_*    : memory instruction from the core (req_ready high in IDLE)
//     mem_*    : word-wide data-memory port (req/gnt, then rvalid for reads)
//     resp_*   : one-cycle completion pulse with load data and error code
// TIMEOUT bounds the wait for mem_rvalid after a load is granted.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst_n,
  lsu_mem_port_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_t    state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]    func3_q;
  logic [1:0]    lo_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [1:0]    err_q;

  logic          accept;
  logic          illegal;
  logic          is_store;
  logic          timeout_hit;
  logic [31:0]   load_val;

  assign accept      = (state == S_IDLE) && bus.req_valid;
  assign is_store    = (bus.req_opcode == OP_S);
  assign illegal     = req_illegal(bus.req_opcode, bus.req_func3, bus.req_addr[1:0]);
  // cnt counts completed WAIT cycles; the TIMEOUT-th one without rvalid aborts.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  lsu_load_align u_align (
    .rdata (bus.mem_rdata),
    .func3 (func3_q),
    .addr  (lo_q),
    .data  (load_val)
  );

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept) state_d = illegal ? S_RESP : S_REQ;
      S_REQ:   if (bus.mem_gnt) state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:  if (bus.mem_rvalid || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      func3_q <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (accept) begin
            func3_q <= bus.req_func3;
            lo_q    <= bus.req_addr[1:0];
            we_q    <= is_store;
            addr_q  <= {bus.req_addr[31:2], 2'b00};
            wstrb_q <= is_store ? store_wstrb(bus.req_func3, bus.req_addr[1:0]) : '0;
            wdata_q <= is_store ? store_wdata(bus.req_func3, bus.req_wdata) : '0;
            rdata_q <= '0;
            err_q   <= illegal ? ERR_ILLEGAL : ERR_OK;
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) cnt <= '0;
        end
        S_WAIT: begin
          // Data arriving on the timeout cycle still completes normally.
          if (bus.mem_rvalid) begin
            rdata_q <= load_val;
            err_q   <= ERR_OK;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          rdata_q <= '0;
          err_q   <= ERR_OK;
        end
        default: ;
      endcase
    end
  end

  // Request/valid strobes decode the state register so reset drops them at once.
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.mem_req    = (state == S_REQ);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
`timescale 1ns/1ps
module tb_lsu_mem_port;
  import lsu_mem_port_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_port_if bus();

  lsu_mem_port #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_wd;
  } memx_t;

  resp_t resp_q[$];
  memx_t mem_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        fail("resp", "resp_valid with nothing outstanding");
      end else begin : pop_resp
        resp_t e;
        e = resp_q.pop_front();
        chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.name, "_err"}, {30'b0, bus.resp_err}, {30'b0, e.err});
        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Memory-request monitor
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      if (mem_q.size() == 0) begin
        fail("mem", "mem_req asserted with no memory access expected");
      end else if (bus.mem_gnt === 1'b1) begin : pop_mem
        memx_t m;
        m = mem_q.pop_front();
        chk({m.name, "_mem_addr"}, bus.mem_addr, m.addr);
        chk({m.name, "_mem_we"}, {31'b0, bus.mem_we}, {31'b0, m.we});
        chk({m.name, "_mem_wstrb"}, {28'b0, bus.mem_wstrb}, {28'b0, m.wstrb});
        if (m.chk_wd) chk({m.name, "_mem_wdata"}, bus.mem_wdata, m.wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rd < 0: memory never returns read data.
  task automatic txn(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int gd, input int rd, input logic [31:0] mrdata,
                     input logic exp_mem, input logic [3:0] exp_wstrb,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                     input logic [1:0] exp_err, input int exp_lat);
    resp_t r;
    memx_t m;
    chk({name, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_func3  = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    step();
    // Scramble request fields so only registered copies can be used.
    bus.req_valid  = 1'b0;
    bus.req_opcode = 7'h7F;
    bus.req_func3  = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'hCAFE_F00D;
    r.name = name; r.rdata = exp_rdata; r.err = exp_err; r.acc = cyc - 1; r.lat = exp_lat;
    resp_q.push_back(r);
    chk({name, "_busy"}, {31'b0, bus.req_ready}, 32'd0);
    if (exp_mem) begin
      m.name = name; m.addr = {addr[31:2], 2'b00}; m.we = (op == OP_S);
      m.wstrb = exp_wstrb; m.wdata = exp_wdata; m.chk_wd = (op == OP_S);
      mem_q.push_back(m);
      for (int i = 0; i < gd; i++) begin
        chk({name, "_stall_req"}, {31'b0, bus.mem_req}, 32'd1);
        chk({name, "_stall_addr"}, bus.mem_addr, m.addr);
        chk({name, "_stall_wstrb"}, {28'b0, bus.mem_wstrb}, {28'b0, m.wstrb});
        chk({name, "_stall_we"}, {31'b0, bus.mem_we}, {31'b0, m.we});
        step();
      end
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      if (op == OP_L && rd >= 0) begin
        for (int i = 0; i < rd; i++) step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mrdata;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h5A5A_5A5A;
      end
    end
    for (int i = 0; i < 64 && resp_q.size() != 0; i++) step();
    if (resp_q.size() != 0) begin
      fail({name, "_resp_wait"}, "no response within 64 cycles");
      resp_q.delete();
    end
    if (mem_q.size() != 0) begin
      fail({name, "_mem_wait"}, "expected memory request never granted");
      mem_q.delete();
    end
  endtask

  task automatic st(input string name, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input int gd,
                    input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
    txn(name, OP_S, f3, addr, wd, gd, 0, 32'h0, 1'b1, exp_wstrb, exp_wdata,
        32'h0, ERR_OK, 2 + gd);
  endtask

  task automatic ld(input string name, input logic [2:0] f3, input logic [31:0] addr,
                    input int gd, input int rd, input logic [31:0] mrdata,
                    input logic [31:0] exp_rdata, input logic [1:0] exp_err, input int exp_lat);
    txn(name, OP_L, f3, addr, 32'h0, gd, rd, mrdata, 1'b1, 4'b0000, 32'h0,
        exp_rdata, exp_err, exp_lat);
  endtask

  task automatic bad(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] addr);
    txn(name, op, f3, addr, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 4'b0000, 32'h0,
        32'h0, ERR_ILLEGAL, 1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    chk({name, "_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
    chk({name, "_mem_we"}, {31'b0, bus.mem_we}, 32'd0);
    chk({name, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    chk({name, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({name, "_mem_wstrb"}, {28'b0, bus.mem_wstrb}, 32'd0);
    chk({name, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({name, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({name, "_resp_err"}, {30'b0, bus.resp_err}, 32'd0);
  endtask

  localparam logic [31:0] RD = 32'h80F0_7F01;

  initial begin
    memx_t m;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_func3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Stores
    st("sw",  F3_SW, 32'h0000_1000, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
    st("sb3", F3_SB, 32'h0000_1003, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5);
    st("sh2", F3_SH, 32'h0000_1002, 32'h0000_1234, 0, 4'b1100, 32'h1234_1234);
    st("sb1", F3_SB, 32'h0000_1001, 32'h1234_5677, 2, 4'b0010, 32'h7777_7777);
    st("sh0", F3_SH, 32'h0000_1000, 32'hABCD_9876, 0, 4'b0011, 32'h9876_9876);

    // Loads from 0x80F07F01
    ld("lb3",  F3_LB,  32'h0000_2003, 0, 0, RD, 32'hFFFF_FF80, ERR_OK, 3);
    ld("lbu3", F3_LBU, 32'h0000_2003, 0, 0, RD, 32'h0000_0080, ERR_OK, 3);
    ld("lh2",  F3_LH,  32'h0000_2002, 0, 0, RD, 32'hFFFF_80F0, ERR_OK, 3);
    ld("lhu0", F3_LHU, 32'h0000_2000, 0, 0, RD, 32'h0000_7F01, ERR_OK, 3);
    ld("lw0",  F3_LW,  32'h0000_2000, 0, 0, RD, 32'h80F0_7F01, ERR_OK, 3);
    ld("lb1",  F3_LB,  32'h0000_2001, 0, 0, RD, 32'h0000_007F, ERR_OK, 3);
    ld("lh0",  F3_LH,  32'h0000_2000, 0, 0, RD, 32'h0000_7F01, ERR_OK, 3);
    ld("lhu2", F3_LHU, 32'h0000_2002, 1, 2, RD, 32'h0000_80F0, ERR_OK, 6);

    // Illegal requests: no memory access, response next cycle
    bad("lw_mis",  OP_L, F3_LW, 32'h0000_2002);
    bad("sh_mis",  OP_S, F3_SH, 32'h0000_2001);
    bad("lh_mis",  OP_L, F3_LH, 32'h0000_2001);
    bad("l_f3_3",  OP_L, 3'b011, 32'h0000_2000);
    bad("s_f3_4",  OP_S, 3'b100, 32'h0000_2000);
    bad("bad_op",  7'b0110011, 3'b000, 32'h0000_2000);

    // Timeout: gnt held low 5 cycles, no rvalid
    ld("lw_to",    F3_LW, 32'h0000_3000, 5, -1, RD, 32'h0, ERR_TIMEOUT, 2 + 5 + TO);
    // rvalid on the timeout cycle wins
    ld("lw_edge",  F3_LW, 32'h0000_3004, 0, TO - 1, 32'h1357_9BDF, 32'h1357_9BDF, ERR_OK, 2 + TO);
    // rvalid one cycle too late lands in RESP and is ignored
    ld("lw_late",  F3_LW, 32'h0000_3008, 0, TO, 32'h2468_ACE0, 32'h0, ERR_TIMEOUT, 2 + TO);
    ld("lb_after", F3_LB, 32'h0000_3000, 0, 0, RD, 32'h0000_0001, ERR_OK, 3);

    // gnt/rvalid while idle are ignored
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    chk("idle_ignore_ready", {31'b0, bus.req_ready}, 32'd1);

    // Reset while waiting for load data
    bus.req_valid = 1'b1; bus.req_opcode = OP_L; bus.req_func3 = F3_LW;
    bus.req_addr = 32'h0000_4000;
    step();
    bus.req_valid = 1'b0;
    m.name = "rst_ld"; m.addr = 32'h0000_4000; m.we = 1'b0; m.wstrb = 4'b0000;
    m.wdata = 32'h0; m.chk_wd = 1'b0;
    mem_q.push_back(m);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("postrst_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_rvalid = 1'b0;
    repeat (3) step();
    chk("postrst_idle", {31'b0, bus.req_ready}, 32'd1);
    chk("postrst_memq", 32'(mem_q.size()), 32'd0);

    st("sw_after", F3_SW, 32'h0000_5004, 32'h0BAD_F00D, 0, 4'b1111, 32'h0BAD_F00D);

    repeat (3) step();
    chk("final_respq", 32'(resp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
